// File: rtl/missile_gfx_pkg.sv
// Shared graphics definitions for the missile-command pixel path:
// screen geometry, coordinate/color widths, palette and the packed pixel record.
package missile_gfx_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int C_W      = 3;

  localparam logic [C_W-1:0] BLACK   = 3'd0;
  localparam logic [C_W-1:0] BLUE    = 3'd1;
  localparam logic [C_W-1:0] GREEN   = 3'd2;
  localparam logic [C_W-1:0] CYAN    = 3'd3;
  localparam logic [C_W-1:0] RED     = 3'd4;
  localparam logic [C_W-1:0] MAGENTA = 3'd5;
  localparam logic [C_W-1:0] YELLOW  = 3'd6;
  localparam logic [C_W-1:0] WHITE   = 3'd7;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] color;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel records with occupancy count; async active-high reset.
module pixel_fifo
  import missile_gfx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(pixel_t),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_arbiter.sv
// Round-robin arbiter over the sprite drawers: clips off-screen pixels, queues the
// rest and feeds the vga_adapter write port at most one pixel per clock.
module pixel_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int X_W        = missile_gfx_pkg::X_W,
  parameter int Y_W        = missile_gfx_pkg::Y_W,
  parameter int C_W        = missile_gfx_pkg::C_W,
  parameter int SCREEN_W   = missile_gfx_pkg::SCREEN_W,
  parameter int SCREEN_H   = missile_gfx_pkg::SCREEN_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC*X_W-1:0] src_x,
  input  logic [NUM_SRC*Y_W-1:0] src_y,
  input  logic [NUM_SRC*C_W-1:0] src_color,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic                   vga_ready,
  output logic                   plot,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_color,
  output logic                   busy,
  output logic [15:0]            drop_count
);

  localparam int PW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PIX_W = X_W + Y_W + C_W;
  localparam logic [X_W:0] LIM_X = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] LIM_Y = (Y_W+1)'(SCREEN_H);

  logic [PW-1:0]    r_rr;
  logic             r_plot;
  logic [X_W-1:0]   r_vga_x;
  logic [Y_W-1:0]   r_vga_y;
  logic [C_W-1:0]   r_vga_color;
  logic             r_busy;
  logic [15:0]      r_drop_count;

  logic             w_found;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_idx;
  logic             w_xfer;
  logic [X_W-1:0]   w_sel_x;
  logic [Y_W-1:0]   w_sel_y;
  logic [C_W-1:0]   w_sel_c;
  logic             w_in_range;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [AW:0]      w_cnt_nxt;
  logic [PIX_W-1:0] w_head;

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_idx = ((32'(r_rr) + k) >= NUM_SRC) ? PW'(32'(r_rr) + k - NUM_SRC) : PW'(32'(r_rr) + k);
      if (!w_found && src_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
  end

  // A full FIFO blocks grants even when a pop happens in the same cycle.
  assign src_ready = (rst || w_full || !w_found) ? '0 : (NUM_SRC'(1) << w_gidx);
  assign w_xfer    = |src_ready;

  assign w_sel_x    = src_x[w_gidx*X_W +: X_W];
  assign w_sel_y    = src_y[w_gidx*Y_W +: Y_W];
  assign w_sel_c    = src_color[w_gidx*C_W +: C_W];
  assign w_in_range = ({1'b0, w_sel_x} < LIM_X) && ({1'b0, w_sel_y} < LIM_Y);

  assign w_push    = w_xfer & w_in_range;
  assign w_pop     = ~w_empty & vga_ready;
  assign w_cnt_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({w_sel_x, w_sel_y, w_sel_c}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // busy is registered from next-state values so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr         <= '0;
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_color  <= '0;
      r_busy       <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_xfer) begin
        r_rr <= (w_gidx == PW'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;
        if (!w_in_range && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
      end
      r_plot <= w_pop;
      if (w_pop) {r_vga_x, r_vga_y, r_vga_color} <= w_head;
      r_busy <= (w_cnt_nxt != '0) | w_pop;
    end
  end

  assign plot       = r_plot;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_color  = r_vga_color;
  assign busy       = r_busy;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Scoreboard bench for pixel_arbiter: a reference model predicts grants, clipping
// and the plotted pixel stream; the queue holds pixels expected at the output.
module tb_pixel_arbiter;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_valid;
  logic [35:0] src_x;
  logic [31:0] src_y;
  logic [11:0] src_color;
  logic [3:0]  src_ready;
  logic        vga_ready;
  logic        plot;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_color;
  logic        busy;
  logic [15:0] drop_count;

  pixel_arbiter #(
    .NUM_SRC    (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_x      (src_x),
    .src_y      (src_y),
    .src_color  (src_color),
    .src_ready  (src_ready),
    .vga_ready  (vga_ready),
    .plot       (plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pix_t        cq[4][$];
  pix_t        sb[$];
  int          m_rr;
  int unsigned m_drop;
  bit          m_plot;
  pix_t        m_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pix_t mk(input int x, input int y, input int c);
    pix_t p;
    p.x = 9'(x);
    p.y = 8'(y);
    p.c = 3'(c);
    return p;
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) cq[i].delete();
    m_rr   = 0;
    m_drop = 0;
    m_plot = 1'b0;
    m_out  = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = (cq[i].size() != 0);
      if (cq[i].size() != 0) begin
        src_x[i*9 +: 9]     = cq[i][0].x;
        src_y[i*8 +: 8]     = cq[i][0].y;
        src_color[i*3 +: 3] = cq[i][0].c;
      end else begin
        src_x[i*9 +: 9]     = '0;
        src_y[i*8 +: 8]     = '0;
        src_color[i*3 +: 3] = '0;
      end
    end
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic step();
    int   eg;
    bit   pop_now;
    pix_t p;
    drive();
    #1;
    eg = -1;
    if (sb.size() < 8)
      for (int k = 0; k < 4; k++)
        if (eg < 0 && src_valid[(m_rr + k) % 4]) eg = (m_rr + k) % 4;
    check("grant", 32'(src_ready), (eg >= 0) ? (32'd1 << eg) : 32'd0);
    @(posedge clk);
    pop_now = (sb.size() != 0) && vga_ready;
    if (pop_now) m_out = sb.pop_front();
    if (eg >= 0) begin
      p = cq[eg].pop_front();
      if (p.x < 320 && p.y < 240) sb.push_back(p);
      else if (m_drop != 32'hFFFF) m_drop++;
      m_rr = (eg + 1) % 4;
    end
    m_plot = pop_now;
    @(negedge clk);
    check("plot", 32'(plot), 32'(m_plot));
    check("vga_x", 32'(vga_x), 32'(m_out.x));
    check("vga_y", 32'(vga_y), 32'(m_out.y));
    check("vga_color", 32'(vga_color), 32'(m_out.c));
    check("busy", 32'(busy), 32'((sb.size() != 0) || m_plot));
    check("drop_count", 32'(drop_count), m_drop);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_plot"}, 32'(plot), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(src_ready), 32'd0);
    check({tag, "_drop"}, 32'(drop_count), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    vga_ready = 1'b0;
    src_valid = 4'hF;
    src_x     = '0;
    src_y     = '0;
    src_color = '0;
    model_reset();
    @(negedge clk);
    #1;
    reset_checks("rst_init");
    @(negedge clk);
    rst = 1'b0;
    drive();

    // single client, back-to-back transfers
    vga_ready = 1'b1;
    cq[0].push_back(mk(80, 203, 2));
    cq[0].push_back(mk(81, 203, 2));
    run(4);

    // all clients requesting continuously
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++) cq[i].push_back(mk(10 * i + j, 20 + i, i + j));
    run(27);

    // only clients 1 and 3
    for (int j = 0; j < 4; j++) begin
      cq[1].push_back(mk(100 + j, 50, 5));
      cq[3].push_back(mk(200 + j, 60, 6));
    end
    run(11);

    // backpressure: FIFO fills to 8 then grants stop
    vga_ready = 1'b0;
    for (int j = 0; j < 10; j++) cq[2].push_back(mk(30 + j, 100 + j, j));
    run(12);
    vga_ready = 1'b1;
    run(14);

    // clipping at both screen edges
    cq[0].push_back(mk(320, 10, 1));
    cq[0].push_back(mk(5, 240, 4));
    cq[0].push_back(mk(319, 239, 7));
    run(6);

    // reset in the middle of a burst
    vga_ready = 1'b0;
    for (int j = 0; j < 7; j++) cq[0].push_back(mk(60 + j, 70, 3));
    run(5);
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    @(negedge clk);
    #1;
    reset_checks("rst_hold");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    vga_ready = 1'b1;
    run(4);

    // drop_count saturation from a preloaded value
    force dut.r_drop_count = 16'hFFFE;
    #1;
    release dut.r_drop_count;
    m_drop = 32'hFFFE;
    cq[1].push_back(mk(400, 10, 1));
    cq[1].push_back(mk(10, 250, 2));
    cq[1].push_back(mk(511, 255, 3));
    cq[1].push_back(mk(7, 8, 4));
    cq[1].push_back(mk(320, 240, 5));
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
